// File: rtl/as_rv32i_regfile_mp.sv
// Multi-read-port integer register file with a post-reset hardware clear sweep.
// Optional same-cycle write-to-read bypass: define AS_REGFILE_BYPASS_EN.
module as_rv32i_regfile_mp #(
    parameter int XLEN  = 32,
    parameter int AW    = 5,
    parameter int NREAD = 2
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_ce_read,
    input  logic [NREAD*AW-1:0]   i_rs_addr,
    input  logic [AW-1:0]         i_rd_addr,
    input  logic [XLEN-1:0]       i_rd,
    input  logic                  i_wr,
    output logic [NREAD*XLEN-1:0] o_rs,
    output logic                  o_ready
);

    localparam int            DEPTH     = 1 << AW;
    localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);
    localparam logic [AW-1:0] ZERO_ADDR = {AW{1'b0}};

    typedef enum logic [0:0] {
        CLEAR = 1'b0,
        READY = 1'b1
    } state_t;

    state_t            state_r;
    logic [AW-1:0]     ptr_r;
    logic              ready_r;
    logic [XLEN-1:0]   mem_r [DEPTH];
    logic [AW-1:0]     cap_r [NREAD];

    logic              we_s;
    logic [AW-1:0]     waddr_s;
    logic [XLEN-1:0]   wdata_s;

    // Clear sequencer: sweeps registers 1..DEPTH-1, then holds READY until reset.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_r <= CLEAR;
            ptr_r   <= AW'(1);
            ready_r <= 1'b0;
        end else begin
            case (state_r)
                CLEAR: begin
                    ptr_r <= ptr_r + AW'(1);
                    if (ptr_r == LAST_ADDR) begin
                        state_r <= READY;
                        ready_r <= 1'b1;
                    end else begin
                        state_r <= CLEAR;
                        ready_r <= 1'b0;
                    end
                end
                READY: begin
                    state_r <= READY;
                    ready_r <= 1'b1;
                end
                default: begin
                    state_r <= CLEAR;
                    ptr_r   <= AW'(1);
                    ready_r <= 1'b0;
                end
            endcase
        end
    end

    // Single array write port, shared between the clear sweep and writeback.
    always_comb begin
        we_s    = 1'b0;
        waddr_s = ZERO_ADDR;
        wdata_s = {XLEN{1'b0}};
        if (i_rst) begin
            we_s = 1'b0;
        end else if (state_r == CLEAR) begin
            we_s    = 1'b1;
            waddr_s = ptr_r;
            wdata_s = {XLEN{1'b0}};
        end else begin
            we_s    = i_wr && (i_rd_addr != ZERO_ADDR);
            waddr_s = i_rd_addr;
            wdata_s = i_rd;
        end
    end

    // Register array storage; entry 0 is never written and reads as zero.
    always_ff @(posedge i_clk) begin
        if (we_s) begin
            mem_r[waddr_s] <= wdata_s;
        end else begin
            mem_r[waddr_s] <= mem_r[waddr_s];
        end
    end

    // Read-address capture at the DECODE clock enable.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            for (int k = 0; k < NREAD; k++) begin
                cap_r[k] <= ZERO_ADDR;
            end
        end else if (i_ce_read) begin
            for (int k = 0; k < NREAD; k++) begin
                cap_r[k] <= i_rs_addr[k*AW +: AW];
            end
        end else begin
            for (int k = 0; k < NREAD; k++) begin
                cap_r[k] <= cap_r[k];
            end
        end
    end

    // Combinational read of each captured address.
    always_comb begin
        o_rs = {(NREAD*XLEN){1'b0}};
        for (int k = 0; k < NREAD; k++) begin
            if (cap_r[k] == ZERO_ADDR) begin
                o_rs[k*XLEN +: XLEN] = {XLEN{1'b0}};
`ifdef AS_REGFILE_BYPASS_EN
            end else if (ready_r && i_wr && (i_rd_addr == cap_r[k])) begin
                o_rs[k*XLEN +: XLEN] = i_rd;
`endif
            end else begin
                o_rs[k*XLEN +: XLEN] = mem_r[cap_r[k]];
            end
        end
    end

    assign o_ready = ready_r;

endmodule

// File: tb/tb_as_rv32i_regfile_mp.sv
// Self-checking bench for as_rv32i_regfile_mp: directed steps plus random traffic vs a reference model.
module tb_as_rv32i_regfile_mp;

    localparam int XLEN  = 32;
    localparam int AW    = 5;
    localparam int NREAD = 2;
    localparam int DEPTH = 32;

    logic                  clk = 1'b0;
    logic                  rst;
    logic                  ce;
    logic [NREAD*AW-1:0]   rs_addr;
    logic [AW-1:0]         rd_addr;
    logic [XLEN-1:0]       rd;
    logic                  wr;
    logic [NREAD*XLEN-1:0] rs;
    logic                  ready;

    int checks   = 0;
    int failures = 0;

    logic [XLEN-1:0] m_mem   [DEPTH];
    bit              m_valid [DEPTH];
    int              m_left;
    bit              m_ready;
    logic [AW-1:0]   m_cap   [NREAD];

    as_rv32i_regfile_mp #(.XLEN(XLEN), .AW(AW), .NREAD(NREAD)) dut (
        .i_clk     (clk),
        .i_rst     (rst),
        .i_ce_read (ce),
        .i_rs_addr (rs_addr),
        .i_rd_addr (rd_addr),
        .i_rd      (rd),
        .i_wr      (wr),
        .o_rs      (rs),
        .o_ready   (ready)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic drive(input bit r, input bit c, input logic [NREAD*AW-1:0] ra,
                         input bit w, input logic [AW-1:0] wa, input logic [XLEN-1:0] wd);
        rst     = r;
        ce      = c;
        rs_addr = ra;
        wr      = w;
        rd_addr = wa;
        rd      = wd;
    endtask

    // Compare outputs against the model for the inputs currently applied.
    task automatic check_outputs(input string tag);
        logic [AW-1:0]   a;
        logic [XLEN-1:0] e;
        bit              known;
        #1;
        check_val({tag, "_ready"}, {63'd0, ready}, {63'd0, m_ready});
        for (int k = 0; k < NREAD; k++) begin
            a     = m_cap[k];
            known = 1'b1;
            e     = '0;
            if (a == '0) begin
                e = '0;
`ifdef AS_REGFILE_BYPASS_EN
            end else if (m_ready && wr && rd_addr != '0 && rd_addr == a) begin
                e = rd;
`endif
            end else if (m_valid[a]) begin
                e = m_mem[a];
            end else begin
                known = 1'b0;
            end
            if (known) begin
                check_val($sformatf("%s_port%0d", tag, k), {32'd0, rs[k*XLEN +: XLEN]}, {32'd0, e});
            end
        end
    endtask

    // Advance one edge and apply the architectural effect of the current inputs to the model.
    task automatic tick();
        @(posedge clk);
        if (rst) begin
            m_ready = 1'b0;
            m_left  = DEPTH - 1;
            for (int i = 0; i < DEPTH; i++) m_valid[i] = 1'b0;
            for (int k = 0; k < NREAD; k++) m_cap[k] = '0;
        end else begin
            if (!m_ready) begin
                m_left--;
                if (m_left == 0) begin
                    m_ready = 1'b1;
                    for (int i = 0; i < DEPTH; i++) begin
                        m_mem[i]   = '0;
                        m_valid[i] = 1'b1;
                    end
                end
            end else if (wr && rd_addr != '0) begin
                m_mem[rd_addr] = rd;
            end
            if (ce) begin
                for (int k = 0; k < NREAD; k++) m_cap[k] = rs_addr[k*AW +: AW];
            end
        end
        #1;
    endtask

    initial begin
        int cnt;
        logic [XLEN-1:0] same_exp;
        m_ready = 1'b0;
        m_left  = 0;
        for (int i = 0; i < DEPTH; i++) begin
            m_valid[i] = 1'b0;
            m_mem[i]   = '0;
        end
        for (int k = 0; k < NREAD; k++) m_cap[k] = '0;

        // Reset, then clear sweep with writes to x5 that must be dropped.
        drive(1, 0, '0, 0, '0, '0);
        tick();
        check_outputs("reset");
        check_val("reset_rs", {32'd0, rs}, 64'd0);
        cnt = 0;
        drive(0, 0, '0, 0, '0, '0);
        while (!ready && cnt < 40) begin
            drive(0, 0, '0, (cnt >= 3 && cnt < 8), 5'd5, 32'hDEADBEEF);
            check_outputs("clear");
            tick();
            cnt++;
        end
        check_val("clear_cycles", 64'(cnt), 64'd31);
        drive(0, 0, '0, 0, '0, '0);
        check_outputs("ready");

        // Every register reads zero after the sweep.
        for (int a = 1; a < DEPTH; a += 2) begin
            drive(0, 1, {5'(a + 1), 5'(a)}, 0, '0, '0);
            tick();
            drive(0, 0, '0, 0, '0, '0);
            check_outputs($sformatf("zeroed_%0d", a));
        end
        drive(0, 1, {5'd1, 5'd5}, 0, '0, '0);
        tick();
        drive(0, 0, '0, 0, '0, '0);
        check_val("dropped_x5", {32'd0, rs[31:0]}, 64'd0);

        // Basic read/write.
        drive(0, 0, '0, 1, 5'd7, 32'h12345678);
        tick();
        drive(0, 0, '0, 1, 5'd9, 32'hCAFEF00D);
        tick();
        drive(0, 1, {5'd9, 5'd7}, 0, '0, '0);
        tick();
        drive(0, 0, '0, 0, '0, '0);
        check_outputs("basic");
        check_val("basic_rs", rs, {32'hCAFEF00D, 32'h12345678});

        // Register zero discards writes; held capture ignores address changes.
        drive(0, 1, {5'd0, 5'd0}, 1, 5'd0, 32'hFFFFFFFF);
        tick();
        drive(0, 0, {5'd9, 5'd7}, 0, '0, '0);
        check_outputs("x0");
        check_val("x0_rs", rs, 64'd0);
        tick();
        check_outputs("hold");
        check_val("hold_rs", rs, 64'd0);

        // Same-cycle write and read of x3.
        drive(0, 0, '0, 1, 5'd3, 32'h1);
        tick();
        drive(0, 1, {5'd0, 5'd3}, 0, '0, '0);
        tick();
        drive(0, 0, '0, 1, 5'd3, 32'h2);
`ifdef AS_REGFILE_BYPASS_EN
        same_exp = 32'h2;
`else
        same_exp = 32'h1;
`endif
        check_outputs("same_cycle");
        check_val("same_cycle_rs", {32'd0, rs[31:0]}, {32'd0, same_exp});
        tick();
        drive(0, 0, '0, 0, '0, '0);
        check_val("after_edge_rs", {32'd0, rs[31:0]}, 64'd2);

        // Reset ten cycles into the sweep restarts it.
        drive(1, 0, '0, 0, '0, '0);
        tick();
        for (int i = 0; i < 10; i++) begin
            drive(0, 1'($urandom_range(1)), '0, 1, 5'd4, $urandom);
            check_outputs("midclear");
            tick();
        end
        drive(1, 0, '0, 0, '0, '0);
        tick();
        cnt = 0;
        while (!ready && cnt < 40) begin
            drive(0, 0, '0, 0, '0, '0);
            check_outputs("reclear");
            check_val("reclear_rs", rs, 64'd0);
            tick();
            cnt++;
        end
        check_val("reclear_cycles", 64'(cnt), 64'd31);

        // Random traffic against the model, with occasional resets.
        for (int i = 0; i < 400; i++) begin
            drive(($urandom_range(99) == 0), 1'($urandom_range(1)), NREAD*AW'($urandom),
                  1'($urandom_range(1)), AW'($urandom_range(3) == 0 ? 0 : $urandom), $urandom);
            check_outputs("rand");
            tick();
        end
        drive(0, 0, '0, 0, '0, '0);
        check_outputs("final");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/as_rv32i_regfile_mp.md
Name: as_rv32i_regfile_mp

Overview:
- Parametrised successor to the base integer register file.
- Configurable data width, register count and number of read ports.
- Has a hardware clear sequencer that zeroes every register after reset, plus an optional same-cycle write-to-read bypass.
- Sits between the DECODE stage (read-address capture) and the WRITEBACK stage (write port) of the core pipeline.

Parameters:
- XLEN, 32: data width of each register in bits.
- AW, 5: address width; depth is 2**AW registers, and register 0 is hardwired to zero.
- NREAD, 2: number of read ports, legal range 1..4.

Ports:
- i_clk  input  1  single clock; all state updates on the rising edge.
- i_rst  input  1  synchronous, active-high reset.
- i_ce_read  input  1  read-address capture enable (DECODE stage clock enable).
- i_rs_addr  input  NREAD*AW  packed read addresses; port k uses bits [k*AW +: AW].
- i_rd_addr  input  AW  write (destination) address.
- i_rd  input  XLEN  write data.
- i_wr  input  1  write enable.
- o_rs  output  NREAD*XLEN  packed read data; port k uses bits [k*XLEN +: XLEN].
- o_ready  output  1  high once the clear sequence has finished and the file accepts writes.

Behaviour:
- FSM has two states, CLEAR and READY.
  - i_rst forces CLEAR, sets the clear pointer to 1 and sets every captured read address to 0, regardless of state.
- CLEAR state:
  - Each cycle, writes 0 to the register at the pointer, then increments the pointer.
  - When the pointer reaches 2**AW-1, that register is written and the FSM moves to READY on the next edge.
  - Total duration is 2**AW-1 cycles after the reset cycle (31 cycles for AW=5).
  - o_ready is low throughout; i_wr is ignored (the write is dropped, not queued).
  - i_ce_read capture still operates.
- READY state: o_ready=1; normal operation.
- Reset while in CLEAR restarts the sweep from pointer 1. Reset while in READY re-enters CLEAR.
- Write path: on a rising edge with o_ready=1, i_wr=1 and i_rd_addr!=0, the register at i_rd_addr takes i_rd. Writes to address 0 are discarded.
- Read path:
  - On a rising edge with i_ce_read=1, every port's address is registered. With i_ce_read=0 the captured addresses hold.
  - o_rs for port k is a combinational read of the register at its captured address.
  - When the captured address is 0, that port outputs 0.
  - Latency: data appears the cycle after capture.
  - A write committed at edge N is visible on any port whose captured address matches from edge N onward.
- Multiple ports may capture the same address; each returns identical data.
- Reset values:
  - o_ready=0.
  - o_rs = all zero, since captured addresses are 0 after reset.
  - Array contents before the clear completes are undefined except register 0, which always reads 0.
- Width rules: addresses are unsigned AW bits, so no out-of-range case exists. Data is stored unmodified, XLEN bits.

Optional Feature:
- Macro: AS_REGFILE_BYPASS_EN.
- Defined:
  - Each port's o_rs muxes in i_rd combinationally when i_wr=1, o_ready=1, i_rd_addr!=0 and i_rd_addr equals that port's captured address.
  - The reader therefore sees the value being written in the same cycle, before the edge that commits it.
  - The bypass never applies to address 0 or during CLEAR.
- Not defined:
  - o_rs reflects array contents only.
  - A same-cycle write becomes visible one edge later.

Test Plan:
- Clear sequence (AW=5): assert i_rst for 1 cycle, then hold i_wr=0 -> o_ready goes high exactly 31 cycles after reset deasserts. Capturing addresses 1..31 afterwards reads 0 on every port.
- Write during clear: during CLEAR drive i_wr=1, i_rd_addr=5, i_rd=32'hDEADBEEF; after READY capture addr 5 -> o_rs port0 = 0.
- Basic read/write: in READY write 32'h12345678 to x7 and 32'hCAFEF00D to x9; capture port0=7, port1=9 -> next cycle o_rs = {32'hCAFEF00D, 32'h12345678}.
- Register zero: write 32'hFFFFFFFF to x0, capture x0 on both ports -> o_rs = 0. Hold i_ce_read=0 and change i_rs_addr -> outputs unchanged.
- Same-cycle write/read: captured port0=3 holds x3=32'h1; drive i_wr=1, addr 3, data 32'h2.
  - With AS_REGFILE_BYPASS_EN: o_rs port0 = 32'h2 in that same cycle.
  - Without it: 32'h1 in that cycle, then 32'h2 after the edge.
- Reset mid-clear: pulse i_rst 10 cycles into CLEAR -> o_ready rises 31 cycles after the second reset deasserts. o_rs = 0 throughout.
